// File: rtl/grid_diffusion_stepper.sv
// 4x4 explicit heat-diffusion stepper: loads a grid, runs N Jacobi iterations one cell per clock.
// Define GRID_PERIODIC_BOUNDARY_EN for toroidal neighbours; default is a zero (Dirichlet) border.
module grid_diffusion_stepper #(
  parameter int unsigned ALPHA_SHIFT = 3,
  parameter int unsigned STEP_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        IN11, IN12, IN13, IN14,
  input  logic [7:0]        IN21, IN22, IN23, IN24,
  input  logic [7:0]        IN31, IN32, IN33, IN34,
  input  logic [7:0]        IN41, IN42, IN43, IN44,
  input  logic              load,
  input  logic              start,
  input  logic [STEP_W-1:0] n_steps,
  output logic              busy,
  output logic              done,
  input  logic [3:0]        rd_addr,
  output logic [7:0]        rd_data
);

  localparam int unsigned CELLS  = 16;
  localparam int unsigned CELL_W = 8;

  typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

  state_t              state, state_d;
  logic                done_d;
  logic [3:0]          idx;
  logic [STEP_W-1:0]   steps_left;
  logic [CELL_W-1:0]   grid      [CELLS];
  logic [CELL_W-1:0]   shadow    [CELLS];
  logic [CELL_W-1:0]   in_cells  [CELLS];

  logic [1:0]          row, col;
  logic [CELL_W-1:0]   cell_o, nb_n, nb_s, nb_e, nb_w, new_cell;
  logic [9:0]          sum_c;
  logic signed [10:0]  diff, quot;
  logic [11:0]         upd;

  assign in_cells = '{IN11, IN12, IN13, IN14, IN21, IN22, IN23, IN24,
                      IN31, IN32, IN33, IN34, IN41, IN42, IN43, IN44};

  assign row     = idx[3:2];
  assign col     = idx[1:0];
  assign cell_o  = grid[idx];
  assign rd_data = grid[rd_addr];

  // Neighbour fetch from the committed grid; 2-bit index arithmetic wraps naturally
  always_comb begin
    nb_n = '0;
    nb_s = '0;
    nb_e = '0;
    nb_w = '0;
`ifdef GRID_PERIODIC_BOUNDARY_EN
    nb_n = grid[{row - 2'd1, col}];
    nb_s = grid[{row + 2'd1, col}];
    nb_e = grid[{row, col + 2'd1}];
    nb_w = grid[{row, col - 2'd1}];
`else
    if (row != 2'd0) nb_n = grid[{row - 2'd1, col}];
    if (row != 2'd3) nb_s = grid[{row + 2'd1, col}];
    if (col != 2'd3) nb_e = grid[{row, col + 2'd1}];
    if (col != 2'd0) nb_w = grid[{row, col - 2'd1}];
`endif
  end

  // Laplacian update with flooring shift and saturation to 0..255
  always_comb begin
    sum_c    = 10'(nb_n) + 10'(nb_s) + 10'(nb_e) + 10'(nb_w);
    diff     = $signed({1'b0, sum_c}) - $signed({1'b0, cell_o, 2'b00});
    quot     = diff >>> ALPHA_SHIFT;
    upd      = {quot[10], quot} + {4'b0000, cell_o};
    new_cell = upd[7:0];
    if (upd[11])         new_cell = '0;
    else if (|upd[10:8]) new_cell = '1;
  end

  always_comb begin
    state_d = state;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (!load && start) begin
          if (n_steps == '0) done_d  = 1'b1;
          else               state_d = CALC;
        end
      end
      CALC: begin
        if (idx == 4'd15) state_d = COMMIT;
      end
      COMMIT: begin
        if (steps_left == STEP_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = CALC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      idx        <= '0;
      steps_left <= '0;
      for (int i = 0; i < CELLS; i++) begin
        grid[i]   <= '0;
        shadow[i] <= '0;
      end
    end else begin
      state <= state_d;
      busy  <= (state_d != IDLE);
      done  <= done_d;
      case (state)
        IDLE: begin
          if (load) begin
            for (int i = 0; i < CELLS; i++) grid[i] <= in_cells[i];
          end else if (start && (n_steps != '0)) begin
            steps_left <= n_steps;
            idx        <= '0;
          end
        end
        CALC: begin
          shadow[idx] <= new_cell;
          idx         <= idx + 4'd1;
        end
        COMMIT: begin
          for (int i = 0; i < CELLS; i++) grid[i] <= shadow[i];
          steps_left <= steps_left - STEP_W'(1);
          idx        <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_diffusion_stepper.sv
// Scoreboard bench for grid_diffusion_stepper: two instances (ALPHA_SHIFT 3 and 0) share stimulus,
// an integer reference model predicts the committed grids and the done cycle.
module tb_grid_diffusion_stepper;

  typedef struct packed {
    logic [31:0]  due;
    logic [127:0] g3;
    logic [127:0] g0;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_v;
  logic         load, start;
  logic [7:0]   n_steps;
  logic         busy, done, busy0, done0;
  logic [3:0]   rd_addr, stim_addr, mon_addr;
  logic [7:0]   rd_data, rd_data0;
  logic         sweeping = 1'b0;

  int   vectors = 0;
  int   miscompares = 0;
  int   ncyc = 0;
  int   done_cnt = 0;
  exp_t q[$];
  logic [127:0] m3 = '0;
  logic [127:0] m0 = '0;

  assign rd_addr = sweeping ? mon_addr : stim_addr;

  always #20 clk = ~clk;

  grid_diffusion_stepper #(.ALPHA_SHIFT(3), .STEP_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .IN11(in_v[7:0]),     .IN12(in_v[15:8]),    .IN13(in_v[23:16]),   .IN14(in_v[31:24]),
    .IN21(in_v[39:32]),   .IN22(in_v[47:40]),   .IN23(in_v[55:48]),   .IN24(in_v[63:56]),
    .IN31(in_v[71:64]),   .IN32(in_v[79:72]),   .IN33(in_v[87:80]),   .IN34(in_v[95:88]),
    .IN41(in_v[103:96]),  .IN42(in_v[111:104]), .IN43(in_v[119:112]), .IN44(in_v[127:120]),
    .load(load), .start(start), .n_steps(n_steps), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  grid_diffusion_stepper #(.ALPHA_SHIFT(0), .STEP_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .IN11(in_v[7:0]),     .IN12(in_v[15:8]),    .IN13(in_v[23:16]),   .IN14(in_v[31:24]),
    .IN21(in_v[39:32]),   .IN22(in_v[47:40]),   .IN23(in_v[55:48]),   .IN24(in_v[63:56]),
    .IN31(in_v[71:64]),   .IN32(in_v[79:72]),   .IN33(in_v[87:80]),   .IN34(in_v[95:88]),
    .IN41(in_v[103:96]),  .IN42(in_v[111:104]), .IN43(in_v[119:112]), .IN44(in_v[127:120]),
    .load(load), .start(start), .n_steps(n_steps), .busy(busy0), .done(done0),
    .rd_addr(rd_addr), .rd_data(rd_data0)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Cell (r,c) 0-based; off-grid cells read zero or wrap around
  function automatic int cell_at(input logic [127:0] g, input int r, input int c);
`ifdef GRID_PERIODIC_BOUNDARY_EN
    r = (r + 4) % 4;
    c = (c + 4) % 4;
`else
    if (r < 0 || r > 3 || c < 0 || c > 3) return 0;
`endif
    return int'(g[8*(4*r+c) +: 8]);
  endfunction

  function automatic logic [127:0] ref_step(input logic [127:0] g, input int sh);
    logic [127:0] res;
    int o, s, d, p, qv, v;
    res = '0;
    p = 1 << sh;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o  = cell_at(g, r, c);
        s  = cell_at(g, r-1, c) + cell_at(g, r+1, c) + cell_at(g, r, c-1) + cell_at(g, r, c+1);
        d  = s - 4*o;
        qv = (d >= 0) ? d / p : -((-d + p - 1) / p);
        v  = o + qv;
        if (v < 0)   v = 0;
        if (v > 255) v = 255;
        res[8*(4*r+c) +: 8] = 8'(v);
      end
    end
    return res;
  endfunction

  task automatic do_load(input logic [127:0] v);
    in_v = v;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    m3 = v;
    m0 = v;
  endtask

  task automatic do_start(input int n);
    exp_t it;
    n_steps = 8'(n);
    start = 1'b1;
    it.due = 32'(ncyc + 2 + 17*n);
    for (int k = 0; k < n; k++) begin
      m3 = ref_step(m3, 3);
      m0 = ref_step(m0, 0);
    end
    it.g3 = m3;
    it.g0 = m0;
    q.push_back(it);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", int'(busy), (n != 0) ? 1 : 0);
  endtask

  task automatic wait_idle();
    int t;
    for (t = 0; t < 200; t++) begin
      if (q.size() == 0 && !sweeping) break;
      @(posedge clk); #1;
    end
    if (t == 200) check("wait_idle_timeout", 1, 0);
  endtask

  // Monitor: on every done, pop the expected entry and sweep both committed grids
  initial begin
    exp_t it;
    mon_addr = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst_n && (done || done0)) begin
        done_cnt++;
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          it = q.pop_front();
          check("done_cycle", ncyc, int'(it.due));
          check("done_both", int'(done & done0), 1);
          check("busy_at_done", int'(busy | busy0), 0);
          sweeping = 1'b1;
          for (int a = 0; a < 16; a++) begin
            mon_addr = 4'(a);
            #1;
            check($sformatf("cell%0d_a3", a), int'(rd_data), int'(it.g3[8*a +: 8]));
            check($sformatf("cell%0d_a0", a), int'(rd_data0), int'(it.g0[8*a +: 8]));
          end
          sweeping = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [127:0] exp1;
    int sum, dcnt;
    rst_n = 1'b0; in_v = '0; load = 1'b0; start = 1'b0; n_steps = '0; stim_addr = '0;
    exp1 = 128'h00020200_020C0C02_020C0C02_00020200;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", int'(busy | busy0), 0);
    check("reset_done", int'(done | done0), 0);
    stim_addr = 4'd7; #1;
    check("reset_cell7", int'(rd_data), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Symmetric centre block, one step
    do_load(128'h00000000_00101000_00101000_00000000);
    do_start(1);
    wait_idle();
    sum = 0;
    for (int a = 0; a < 16; a++) begin
      stim_addr = 4'(a); #1;
      sum += int'(rd_data);
      check($sformatf("t1_cell%0d", a), int'(rd_data), int'(exp1[8*a +: 8]));
    end
    check("t1_sum", sum, 64);
    @(posedge clk); #1;

    // Corner impulse exercises the boundary handling
    do_load(128'h40);
    do_start(1);
    wait_idle();
    stim_addr = 4'd0;  #1; check("t2_cell0", int'(rd_data), 8'h20);
    stim_addr = 4'd1;  #1; check("t2_cell1", int'(rd_data), 8'h08);
    stim_addr = 4'd4;  #1; check("t2_cell4", int'(rd_data), 8'h08);
`ifdef GRID_PERIODIC_BOUNDARY_EN
    stim_addr = 4'd3;  #1; check("t2_cell3", int'(rd_data), 8'h08);
    stim_addr = 4'd12; #1; check("t2_cell12", int'(rd_data), 8'h08);
`else
    stim_addr = 4'd3;  #1; check("t2_cell3", int'(rd_data), 8'h00);
    stim_addr = 4'd12; #1; check("t2_cell12", int'(rd_data), 8'h00);
`endif
    @(posedge clk); #1;

    // Saturation at both ends on the ALPHA_SHIFT=0 instance
    do_load(128'h00000000_0000FF00_00FFC8FF_0000FF00);
    do_start(1);
    wait_idle();
    stim_addr = 4'd5; #1; check("sat_hi_cell5", int'(rd_data0), 8'hFF);
    @(posedge clk); #1;
    do_load(128'h00000000_00000000_0000FF00_00000000);
    do_start(1);
    wait_idle();
    stim_addr = 4'd5; #1; check("sat_lo_cell5", int'(rd_data0), 8'h00);
    @(posedge clk); #1;

    // Zero-step run: done next cycle, never busy, grid untouched
    do_start(0);
    check("n0_busy_c2", int'(busy | busy0), 0);
    @(posedge clk); #1;
    check("n0_busy_c3", int'(busy | busy0), 0);
    wait_idle();

    // Load/start while busy must be ignored
    do_load({$urandom, $urandom, $urandom, $urandom});
    do_start(3);
    repeat (5) @(posedge clk);
    #1;
    in_v = {$urandom, $urandom, $urandom, $urandom};
    load = 1'b1; start = 1'b1; n_steps = 8'd5;
    @(posedge clk); #1;
    load = 1'b0; start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1; n_steps = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();

    // Random loads and runs against the reference model
    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 1) == 0) do_load({$urandom, $urandom, $urandom, $urandom});
        else                           do_load({$urandom, $urandom, $urandom, $urandom} & {16{8'h3F}});
      end
      do_start(int'($urandom_range(0, 4)));
      wait_idle();
    end

    // Reset mid-run aborts without a done pulse and clears both grids
    do_load({$urandom, $urandom, $urandom, $urandom});
    do_start(2);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    dcnt = done_cnt;
    #1;
    check("rst_busy", int'(busy | busy0), 0);
    check("rst_done", int'(done | done0), 0);
    for (int a = 0; a < 16; a++) begin
      stim_addr = 4'(a); #1;
      check($sformatf("rst_cell%0d", a), int'(rd_data | rd_data0), 0);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m3 = '0;
    m0 = '0;
    repeat (60) @(posedge clk);
    #1;
    check("rst_no_done", done_cnt, dcnt);

    // Fresh run after the aborted one
    do_load({$urandom, $urandom, $urandom, $urandom});
    do_start(1);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
